// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, redirect and decode-side signals
// of the fetch stage; master = fetch side, slave = memory/decode side.
interface fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        branch;
  logic        branch_ack;
  logic [31:0] branch_pc;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_rdata,
    input  inst_data_ok,
    input  branch,
    output branch_ack,
    input  branch_pc,
    input  ready_i,
    output valid_o,
    output pc_o,
    output inst_o
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_rdata,
    output inst_data_ok,
    output branch,
    input  branch_ack,
    output branch_pc,
    output ready_i,
    input  valid_o,
    input  pc_o,
    input  inst_o
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, one-outstanding instruction requests and a
// 2-entry in-order {pc, inst} buffer feeding decode, with delay-slot redirect.
// Ports: clk; resetn (async, active-low); bus (fetch_stage_if.master):
//   inst_req/inst_addr/inst_addr_ok  request, inst_rdata/inst_data_ok response,
//   branch/branch_pc/branch_ack  redirect, valid_o/ready_i/pc_o/inst_o  head.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input logic           clk,
  input logic           resetn,
  fetch_stage_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_ent_t;

  logic [31:0] fetch_pc_q;
  logic [31:0] fetch_pc_d;
  logic        outst_q;
  logic        outst_d;
  logic [31:0] req_pc_q;
  logic [31:0] req_pc_d;
  fq_ent_t     fq_q [2];
  fq_ent_t     fq_d [2];
  logic        rd_ptr_q;
  logic        rd_ptr_d;
  logic        wr_ptr_q;
  logic        wr_ptr_d;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;

  logic    req;
  logic    valid;
  logic    ack;
  logic    req_fire;
  logic    rsp_fire;
  logic    pop;
  logic    redir;
  fq_ent_t head;

  // Requests are gated by resetn so the bus is quiet while reset is held.
  // Only one request may be in flight, and only when its response has a
  // free slot, so count + outstanding never exceeds 2.
  always_comb begin
    valid    = (cnt_q != 2'd0);
    req      = resetn && !outst_q && (cnt_q < 2'd2);
    ack      = valid && ((cnt_q == 2'd2) || outst_q);
    head     = fq_q[rd_ptr_q];
    req_fire = req && bus.inst_addr_ok;
    rsp_fire = bus.inst_data_ok && outst_q;
    pop      = valid && bus.ready_i;
    redir    = bus.branch && ack;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    req_pc_d   = req_pc_q;
    fq_d[0]    = fq_q[0];
    fq_d[1]    = fq_q[1];
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;

    // A redirect implies ack, which implies no request is offered,
    // so the two PC updates never coincide.
    unique case (1'b1)
      redir: begin
        fetch_pc_d = {bus.branch_pc[31:2], 2'b00};
      end
      req_fire: begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        req_pc_d   = fetch_pc_q;
        outst_d    = 1'b1;
      end
      default: begin
      end
    endcase

    if (rsp_fire) begin
      fq_d[wr_ptr_q] = '{pc: req_pc_q, inst: bus.inst_rdata};
      wr_ptr_d       = ~wr_ptr_q;
      outst_d        = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({rsp_fire, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= 1'b0;
      req_pc_q   <= '0;
      fq_q[0]    <= '0;
      fq_q[1]    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      req_pc_q   <= req_pc_d;
      fq_q[0]    <= fq_d[0];
      fq_q[1]    <= fq_d[1];
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.inst_req   = req;
  assign bus.inst_addr  = fetch_pc_q;
  assign bus.branch_ack = ack;
  assign bus.valid_o    = valid;
  assign bus.pc_o       = head.pc;
  assign bus.inst_o     = head.inst;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a
// queue-based reference model and a program-order tracker.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'hbfc00000;

  logic clk = 1'b0;
  logic resetn;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC(RPC)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total;
  int bad;

  // stimulus knobs
  int unsigned aok_p;
  int unsigned rdy_p;
  int unsigned lat_max;
  int unsigned br_p;
  bit          spur;
  bit          br_force;
  logic [31:0] bpc_force;

  // inputs driven this cycle
  logic        aok;
  logic        rdy;
  logic        dok;
  logic        br;
  logic [31:0] rd;
  logic [31:0] bpc;

  // reference model
  logic [31:0] m_pc;
  logic        m_out;
  logic [31:0] m_rpc;
  logic [31:0] q_pc [$];
  logic [31:0] q_in [$];

  // memory model
  bit          mem_pending;
  logic [31:0] mem_addr;
  int unsigned mem_wait;

  // program-order tracker
  logic [31:0] flow_next;
  bit          flow_pend;
  logic [31:0] flow_tgt;

  function automatic logic [31:0] ifn(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h0000_0013;
  endfunction

  function automatic logic f_valid();
    return q_pc.size() != 0;
  endfunction

  function automatic logic f_req();
    return !m_out && ((q_pc.size() + int'(m_out)) < 2);
  endfunction

  function automatic logic f_ack();
    return f_valid() && (q_pc.size() == 2 || m_out);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    aok = 0; rdy = 0; dok = 0; br = 0; rd = '0; bpc = '0;
    bus.inst_addr_ok = 0;
    bus.inst_data_ok = 0;
    bus.inst_rdata   = '0;
    bus.branch       = 0;
    bus.branch_pc    = '0;
    bus.ready_i      = 0;
  endtask

  task automatic model_reset();
    m_pc  = RPC;
    m_out = 0;
    m_rpc = '0;
    q_pc.delete();
    q_in.delete();
    mem_pending = 0;
    mem_wait    = 0;
    flow_next   = RPC;
    flow_pend   = 0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  task automatic check_outs();
    logic er;
    logic ev;
    er = f_req();
    ev = f_valid();
    chk1("inst_req", bus.inst_req, er);
    if (er) chk("inst_addr", bus.inst_addr, m_pc);
    chk1("valid_o", bus.valid_o, ev);
    chk1("branch_ack", bus.branch_ack, f_ack());
    if (ev) begin
      chk("pc_o", bus.pc_o, q_pc[0]);
      chk("inst_o", bus.inst_o, q_in[0]);
    end
  endtask

  task automatic drive_ins();
    aok = ($urandom_range(99) < aok_p);
    rdy = ($urandom_range(99) < rdy_p);
    dok = mem_pending && (mem_wait == 0);
    if (dok) begin
      rd = ifn(mem_addr);
    end else begin
      rd = $urandom;
      if (!mem_pending && spur && $urandom_range(7) == 0) dok = 1;
    end
    br  = 0;
    bpc = $urandom;
    if (br_force) begin
      br  = 1;
      bpc = bpc_force;
    end else if (br_p != 0 && !flow_pend && $urandom_range(99) < br_p) begin
      br  = 1;
      bpc = $urandom & 32'hffff_fffc;
    end
    // decode pops the branch in the cycle its redirect is taken
    if (br && f_ack()) rdy = 1;
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = rd;
    bus.branch       = br;
    bus.branch_pc    = bpc;
    bus.ready_i      = rdy;
  endtask

  task automatic model_step();
    logic        hs;
    logic        rsp;
    logic        redir;
    logic        pop;
    logic [31:0] p;
    hs    = f_req() && aok;
    rsp   = dok && m_out;
    redir = br && f_ack();
    pop   = f_valid() && rdy;
    if (pop) begin
      p = q_pc.pop_front();
      void'(q_in.pop_front());
      if (redir) begin
        flow_next = p + 32'd4;
        flow_pend = 1;
        flow_tgt  = bpc & 32'hffff_fffc;
      end else if (flow_pend) begin
        flow_next = flow_tgt;
        flow_pend = 0;
      end else begin
        flow_next = p + 32'd4;
      end
    end
    if (rsp) begin
      q_pc.push_back(m_rpc);
      q_in.push_back(rd);
      m_out = 0;
    end
    if (hs) begin
      m_out = 1;
      m_rpc = m_pc;
      m_pc  = m_pc + 32'd4;
    end
    if (redir) m_pc = bpc & 32'hffff_fffc;
    if (hs) begin
      mem_pending = 1;
      mem_addr    = m_rpc;
      mem_wait    = $urandom_range(lat_max, 0);
    end else if (dok && mem_pending) begin
      mem_pending = 0;
    end else if (mem_pending && mem_wait > 0) begin
      mem_wait--;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outs();
    drive_ins();
    if (f_valid() && rdy) chk("flow_pc", bus.pc_o, flow_next);
    @(posedge clk);
    model_step();
  endtask

  task automatic peek();
    #1;
  endtask

  task automatic do_reset();
    #1 resetn = 1'b0;
    drive_idle();
    model_reset();
    @(posedge clk);
    release_reset();
  endtask

  initial begin
    total = 0; bad = 0;
    aok_p = 100; rdy_p = 100; lat_max = 0; br_p = 0;
    spur = 0; br_force = 0; bpc_force = '0;
    drive_idle();
    model_reset();
    resetn = 1'b1;

    #2 resetn = 1'b0;
    #1;
    chk1("rst_valid", bus.valid_o, 1'b0);
    chk1("rst_req", bus.inst_req, 1'b0);
    chk1("rst_ack", bus.branch_ack, 1'b0);
    chk("rst_pc_o", bus.pc_o, 32'h0);
    chk("rst_inst_o", bus.inst_o, 32'h0);
    chk("rst_addr", bus.inst_addr, RPC);
    repeat (2) @(posedge clk);
    release_reset();
    #1;
    chk1("rel_req", bus.inst_req, 1'b1);
    chk("rel_addr", bus.inst_addr, RPC);

    // streaming, memory always ready, one-cycle response
    repeat (12) tick();

    // decode stalled: buffer fills, then drains in order
    do_reset();
    rdy_p = 0;
    repeat (6) tick();
    peek();
    chk1("full_req", bus.inst_req, 1'b0);
    chk("full_head", bus.pc_o, RPC);
    chk1("full_ack", bus.branch_ack, 1'b1);
    rdy_p = 100;
    aok_p = 0;
    tick();
    peek();
    chk("pop2_pc", bus.pc_o, RPC + 32'd4);
    chk("pop2_inst", bus.inst_o, ifn(RPC + 32'd4));

    // redirect with delay slot buffered
    do_reset();
    rdy_p = 0;
    aok_p = 100;
    repeat (6) tick();
    br_force  = 1;
    bpc_force = 32'hbfc00100;
    tick();
    br_force = 0;
    peek();
    chk1("br_valid", bus.valid_o, 1'b1);
    chk("br_slot_pc", bus.pc_o, 32'hbfc00004);
    chk1("br_req", bus.inst_req, 1'b1);
    chk("br_tgt_addr", bus.inst_addr, 32'hbfc00100);

    // branch without ack is ignored
    aok_p     = 0;
    br_force  = 1;
    bpc_force = 32'h12345670;
    tick();
    br_force = 0;
    peek();
    chk("noack_addr", bus.inst_addr, 32'hbfc00100);

    // addr_ok held low for five cycles, then accepted
    repeat (5) tick();
    peek();
    chk1("stall_req", bus.inst_req, 1'b1);
    chk("stall_addr", bus.inst_addr, 32'hbfc00100);
    aok_p = 100;
    tick();
    aok_p = 0;
    peek();
    chk1("hs_req", bus.inst_req, 1'b0);
    chk("hs_addr", bus.inst_addr, 32'hbfc00104);

    // async reset with a request in flight and one entry buffered
    #2 resetn = 1'b0;
    #1;
    chk1("mid_valid", bus.valid_o, 1'b0);
    chk1("mid_req", bus.inst_req, 1'b0);
    chk1("mid_ack", bus.branch_ack, 1'b0);
    chk("mid_pc_o", bus.pc_o, 32'h0);
    drive_idle();
    model_reset();
    @(posedge clk);
    release_reset();
    #1;
    chk1("mid_rel_req", bus.inst_req, 1'b1);
    chk("mid_rel_addr", bus.inst_addr, RPC);

    // random traffic
    aok_p = 70; rdy_p = 75; lat_max = 3; br_p = 15; spur = 1;
    repeat (2000) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
